// File: rtl/ascon_cipher_collector.sv
// rtl/ascon_cipher_collector.sv - collects ascon cipher blocks and tag, streams them out as bytes
//
// Purpose:
//   Output-side companion to the ascon core. Packs up to NB_BLOCKS cipher
//   blocks into a frame buffer (first block most significant), captures the
//   tag, then streams the received cipher bytes followed by the tag bytes,
//   MSB first, over a valid/ready byte interface.
//
// Ports:
//   clock_i         system clock
//   reset_i         asynchronous active-low reset
//   start_i         one-cycle pulse, arms capture of a new frame (IDLE only)
//   cipher_i        cipher block from ascon
//   cipher_valid_i  cipher_i valid this cycle
//   end_cipher_i    ascon produced its last cipher block
//   tag_i           tag from ascon
//   end_tag_i       tag_i valid this cycle
//   byte_o          output byte (0 when byte_valid_o is low)
//   byte_valid_o    byte_o valid
//   byte_ready_i    sink accepts byte_o
//   busy_o          high in any state other than IDLE
//   done_o          one-cycle pulse after the last byte is accepted
//   overflow_o      sticky, a block arrived while the buffer was full
//
// Configuration:
//   ASCON_COLLECT_HEADER_EN  when defined, two header bytes (0xA5, payload
//                            length in bytes) precede the cipher bytes.

module ascon_cipher_collector #(
    parameter int NB_BLOCKS = 23,
    parameter int BLOCK_W   = 64,
    parameter int TAG_W     = 128
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [BLOCK_W-1:0] cipher_i,
    input  logic               cipher_valid_i,
    input  logic               end_cipher_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               end_tag_i,
    output logic [7:0]         byte_o,
    output logic               byte_valid_o,
    input  logic               byte_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               overflow_o
);

    localparam int BUF_W     = NB_BLOCKS * BLOCK_W;
    localparam int BLK_BYTES = BLOCK_W / 8;
    localparam int TAG_BYTES = TAG_W / 8;
    localparam int IW        = $clog2(BUF_W);
    localparam int TW        = $clog2(TAG_W);

`ifdef ASCON_COLLECT_HEADER_EN
    localparam logic [7:0] HDR_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WAIT_TAG,
        SEND_HEADER,
        SEND_CIPHER,
        SEND_TAG,
        DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WAIT_TAG,
        SEND_CIPHER,
        SEND_TAG,
        DONE
    } state_t;
`endif

    state_t             state;
    state_t             send_entry;
    logic [BUF_W-1:0]   buffer;
    logic [TAG_W-1:0]   tag_q;
    logic [4:0]         block_cnt;
    logic [7:0]         byte_cnt;

    logic               full;
    logic               store;
    logic               xfer;
    logic [4:0]         blocks_after;
    logic [7:0]         cipher_bytes;
    logic [IW-1:0]      blk_lsb;
    logic [IW-1:0]      byte_lsb;
    logic [TW-1:0]      tag_lsb;
    logic [7:0]         send_byte;

    always_comb begin
        full         = (block_cnt == 5'(NB_BLOCKS));
        store        = (state == CAPTURE) && cipher_valid_i && !full;
        // Block count as it will be after this cycle's store; decides whether
        // a tag arriving in the same cycle finds any cipher bytes to send.
        blocks_after = store ? block_cnt + 5'd1 : block_cnt;
        xfer         = byte_valid_o && byte_ready_i;
        cipher_bytes = 8'(block_cnt) * 8'(BLK_BYTES);
        blk_lsb      = IW'(BUF_W - BLOCK_W) - IW'(IW'(block_cnt) * IW'(BLOCK_W));
        byte_lsb     = IW'(BUF_W - 8) - IW'({byte_cnt, 3'b000});
        tag_lsb      = TW'(TAG_W - 8) - TW'({byte_cnt, 3'b000});
`ifdef ASCON_COLLECT_HEADER_EN
        send_entry   = SEND_HEADER;
`else
        send_entry   = (blocks_after == 5'd0) ? SEND_TAG : SEND_CIPHER;
`endif
    end

    // Output byte is a pure function of registered state, so it cannot move
    // while the sink stalls.
    always_comb begin
        send_byte = 8'h00;
        if (byte_valid_o) begin
            unique case (state)
`ifdef ASCON_COLLECT_HEADER_EN
                SEND_HEADER: send_byte = (byte_cnt == 8'd0) ? HDR_SYNC
                                                            : cipher_bytes + 8'(TAG_BYTES);
`endif
                SEND_CIPHER: send_byte = buffer[byte_lsb +: 8];
                SEND_TAG:    send_byte = tag_q[tag_lsb +: 8];
                default:     send_byte = 8'h00;
            endcase
        end
    end

    assign byte_o = send_byte;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state        <= IDLE;
            buffer       <= '0;
            tag_q        <= '0;
            block_cnt    <= '0;
            byte_cnt     <= '0;
            byte_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= CAPTURE;
                        busy_o     <= 1'b1;
                        block_cnt  <= '0;
                        byte_cnt   <= '0;
                        overflow_o <= 1'b0;
                    end
                end

                CAPTURE: begin
                    if (store) begin
                        buffer[blk_lsb +: BLOCK_W] <= cipher_i;
                        block_cnt                  <= block_cnt + 5'd1;
                    end else if (cipher_valid_i) begin
                        overflow_o <= 1'b1;
                    end
                    if (end_tag_i) begin
                        tag_q        <= tag_i;
                        byte_cnt     <= '0;
                        state        <= send_entry;
                        byte_valid_o <= 1'b1;
                    end else if (end_cipher_i || blocks_after == 5'(NB_BLOCKS)) begin
                        state <= WAIT_TAG;
                    end
                end

                WAIT_TAG: begin
                    if (cipher_valid_i && full) begin
                        overflow_o <= 1'b1;
                    end
                    if (end_tag_i) begin
                        tag_q        <= tag_i;
                        byte_cnt     <= '0;
                        state        <= send_entry;
                        byte_valid_o <= 1'b1;
                    end
                end

`ifdef ASCON_COLLECT_HEADER_EN
                SEND_HEADER: begin
                    if (xfer) begin
                        if (byte_cnt == 8'd1) begin
                            byte_cnt <= '0;
                            state    <= (block_cnt == 5'd0) ? SEND_TAG : SEND_CIPHER;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
`endif

                SEND_CIPHER: begin
                    if (xfer) begin
                        if (byte_cnt == cipher_bytes - 8'd1) begin
                            byte_cnt <= '0;
                            state    <= SEND_TAG;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end

                SEND_TAG: begin
                    if (xfer) begin
                        if (byte_cnt == 8'(TAG_BYTES - 1)) begin
                            state        <= DONE;
                            byte_valid_o <= 1'b0;
                            done_o       <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state        <= IDLE;
                    byte_valid_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_cipher_collector.sv
// tb/tb_ascon_cipher_collector.sv - directed self-checking bench for ascon_cipher_collector

module tb_ascon_cipher_collector;

    localparam logic [127:0] TAG = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    logic         clock_i = 1'b0;
    logic         reset_i = 1'b0;
    logic         start_i = 1'b0;
    logic [63:0]  cipher_i = '0;
    logic         cipher_valid_i = 1'b0;
    logic         end_cipher_i = 1'b0;
    logic [127:0] tag_i = '0;
    logic         end_tag_i = 1'b0;
    logic [7:0]   byte_o;
    logic         byte_valid_o;
    logic         byte_ready_i = 1'b0;
    logic         busy_o;
    logic         done_o;
    logic         overflow_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         done_cnt;
    int         bubbles;
    int         stable_err;
    bit         timed_out;

    ascon_cipher_collector dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .cipher_i       (cipher_i),
        .cipher_valid_i (cipher_valid_i),
        .end_cipher_i   (end_cipher_i),
        .tag_i          (tag_i),
        .end_tag_i      (end_tag_i),
        .byte_o         (byte_o),
        .byte_valid_o   (byte_valid_o),
        .byte_ready_i   (byte_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic do_reset();
        reset_i = 1'b0;
        repeat (3) @(posedge clock_i);
        #1 reset_i = 1'b1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clock_i); #1;
        start_i = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] data);
        cipher_i       = data;
        cipher_valid_i = 1'b1;
        @(posedge clock_i); #1;
        cipher_valid_i = 1'b0;
    endtask

    task automatic pulse_end_cipher();
        end_cipher_i = 1'b1;
        @(posedge clock_i); #1;
        end_cipher_i = 1'b0;
    endtask

    task automatic pulse_tag();
        tag_i     = TAG;
        end_tag_i = 1'b1;
        @(posedge clock_i); #1;
        end_tag_i = 1'b0;
    endtask

    task automatic send_blocks(input int nb);
        for (int i = 0; i < nb; i++) begin
            logic [7:0] b;
            b = 8'(i + 1);
            send_block({8{b}});
        end
    endtask

    // Expected output stream for a frame of nb stored blocks.
    task automatic build_exp(input int nb);
        exp_q.delete();
`ifdef ASCON_COLLECT_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(nb * 8 + 16));
`endif
        for (int i = 0; i < nb; i++)
            for (int j = 0; j < 8; j++)
                exp_q.push_back(8'(i + 1));
        for (int k = 0; k < 16; k++)
            exp_q.push_back(8'(k * 17));
    endtask

    function automatic int first_diff();
        int n;
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (rx_q[i] !== exp_q[i]) return i;
        if (rx_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Receive bytes until done_o (plus a few cycles) or stop_at bytes,
    // bounded by budget cycles. toggle=1 drives ready 1/0 alternately.
    task automatic collect(input bit toggle, input int budget, input int stop_at);
        bit         held = 1'b0;
        logic [7:0] held_byte = 8'h00;
        bit         started = 1'b0;
        bit         finished = 1'b0;
        int         extra = 0;
        rx_q.delete();
        done_cnt   = 0;
        bubbles    = 0;
        stable_err = 0;
        timed_out  = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (finished) break;
            if (stop_at > 0 && rx_q.size() >= stop_at) begin
                timed_out = 1'b0;
                break;
            end
            byte_ready_i = toggle ? (c % 2 == 0) : 1'b1;
            @(negedge clock_i);
            if (done_o) done_cnt++;
            if (byte_valid_o) begin
                started = 1'b1;
                if (held && byte_o !== held_byte) stable_err++;
                if (byte_ready_i) begin
                    rx_q.push_back(byte_o);
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_byte = byte_o;
                end
            end else if (started && done_cnt == 0) begin
                bubbles++;
            end
            if (done_cnt > 0) begin
                extra++;
                if (extra > 3) begin
                    finished  = 1'b1;
                    timed_out = 1'b0;
                end
            end
            @(posedge clock_i); #1;
        end
        byte_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (byte_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", byte_valid_o); end
        tests++; if (busy_o !== 1'b0)       begin fails++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        tests++; if (done_o !== 1'b0)       begin fails++; $display("FAIL reset_done got=%0b exp=0", done_o); end
        tests++; if (overflow_o !== 1'b0)   begin fails++; $display("FAIL reset_overflow got=%0b exp=0", overflow_o); end
        tests++; if (byte_o !== 8'h00)      begin fails++; $display("FAIL reset_byte got=%h exp=00", byte_o); end
    endtask

    task automatic test_full_frame();
        int d;
        pulse_start();
        tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL full_busy_capture got=%0b exp=1", busy_o); end
        send_blocks(23);
        pulse_end_cipher();
        pulse_tag();
        tests++; if (byte_valid_o !== 1'b1) begin fails++; $display("FAIL full_valid_latency got=%0b exp=1", byte_valid_o); end
        build_exp(23);
        collect(1'b0, 400, 0);
        d = first_diff();
        tests++; if (timed_out)              begin fails++; $display("FAIL full_timeout got=timeout exp=done"); end
        tests++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL full_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        tests++; if (d != -1)                begin fails++; $display("FAIL full_bytes first difference at index %0d", d); end
        tests++; if (done_cnt != 1)          begin fails++; $display("FAIL full_done_pulses got=%0d exp=1", done_cnt); end
        tests++; if (bubbles != 0)           begin fails++; $display("FAIL back_to_back_bubbles got=%0d exp=0", bubbles); end
        tests++; if (overflow_o !== 1'b0)    begin fails++; $display("FAIL full_overflow got=%0b exp=0", overflow_o); end
        tests++; if (busy_o !== 1'b0)        begin fails++; $display("FAIL full_busy_after got=%0b exp=0", busy_o); end
    endtask

    task automatic test_backpressure();
        int d;
        pulse_start();
        send_blocks(23);
        pulse_end_cipher();
        pulse_tag();
        build_exp(23);
        collect(1'b1, 800, 0);
        d = first_diff();
        tests++; if (timed_out)              begin fails++; $display("FAIL bp_timeout got=timeout exp=done"); end
        tests++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        tests++; if (d != -1)                begin fails++; $display("FAIL bp_bytes first difference at index %0d", d); end
        tests++; if (stable_err != 0)        begin fails++; $display("FAIL bp_stable got=%0d changes exp=0", stable_err); end
        tests++; if (done_cnt != 1)          begin fails++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_short_frame();
        int d;
        pulse_start();
        send_blocks(3);
        pulse_end_cipher();
        pulse_tag();
        build_exp(3);
        collect(1'b0, 200, 0);
        d = first_diff();
        tests++; if (timed_out)              begin fails++; $display("FAIL short_timeout got=timeout exp=done"); end
        tests++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL short_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        tests++; if (d != -1)                begin fails++; $display("FAIL short_bytes first difference at index %0d", d); end
        tests++; if (done_cnt != 1)          begin fails++; $display("FAIL short_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_zero_blocks();
        int d;
        pulse_start();
        pulse_end_cipher();
        pulse_tag();
        build_exp(0);
        collect(1'b0, 100, 0);
        d = first_diff();
        tests++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL zero_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        tests++; if (d != -1)                begin fails++; $display("FAIL zero_bytes first difference at index %0d", d); end
        tests++; if (done_cnt != 1)          begin fails++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_overflow();
        int d;
        pulse_start();
        send_blocks(24);
        tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%0b exp=1", overflow_o); end
        pulse_tag();
        build_exp(23);
        collect(1'b0, 400, 0);
        d = first_diff();
        tests++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL ovf_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        tests++; if (d != -1)              begin fails++; $display("FAIL ovf_bytes first difference at index %0d", d); end
        tests++; if (overflow_o !== 1'b1)  begin fails++; $display("FAIL ovf_sticky got=%0b exp=1", overflow_o); end
        pulse_start();
        tests++; if (overflow_o !== 1'b0)  begin fails++; $display("FAIL ovf_clear_on_start got=%0b exp=0", overflow_o); end
        do_reset();
    endtask

    task automatic test_reset_mid_send();
        int d;
        int done_seen = 0;
        pulse_start();
        send_blocks(23);
        pulse_end_cipher();
        pulse_tag();
        collect(1'b0, 100, 50);
        tests++; if (rx_q.size() != 50) begin fails++; $display("FAIL mid_prefix got=%0d exp=50", rx_q.size()); end
        reset_i = 1'b0;
        #1;
        tests++; if (byte_valid_o !== 1'b0) begin fails++; $display("FAIL mid_valid_async got=%0b exp=0", byte_valid_o); end
        tests++; if (busy_o !== 1'b0)       begin fails++; $display("FAIL mid_busy_async got=%0b exp=0", busy_o); end
        repeat (2) begin
            @(negedge clock_i);
            if (done_o) done_seen++;
        end
        @(posedge clock_i); #1 reset_i = 1'b1;
        @(negedge clock_i);
        if (done_o) done_seen++;
        tests++; if (done_seen != 0) begin fails++; $display("FAIL mid_no_done got=%0d exp=0", done_seen); end
        @(posedge clock_i); #1;
        pulse_start();
        send_blocks(3);
        pulse_end_cipher();
        pulse_tag();
        build_exp(3);
        collect(1'b0, 200, 0);
        d = first_diff();
        tests++; if (d != -1)       begin fails++; $display("FAIL mid_restart_bytes first difference at index %0d", d); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL mid_restart_done got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_short_frame();
        test_zero_blocks();
        test_overflow();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ascon_cipher_collector.md
Name: ascon_cipher_collector

Overview:
Output-side companion to fsm_ascon. It consumes the ascon core's result interface (cipher blocks, end_cipher, tag), packs the 64-bit cipher blocks into a frame buffer, and captures the 128-bit tag. It then streams cipher bytes followed by tag bytes, MSB first, over a valid/ready byte interface toward the serial link (UART TX).

Parameters:
NB_BLOCKS, 23, number of 64-bit cipher blocks per frame (23 x 64 = 1472 bits = 184 bytes)
BLOCK_W, 64, cipher block width in bits
TAG_W, 128, tag width in bits

Ports:
clock_i  in  1  system clock
reset_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse; arms capture of a new frame
cipher_i  in  64  cipher block from ascon
cipher_valid_i  in  1  cipher_i is valid this cycle
end_cipher_i  in  1  ascon has produced its last cipher block
tag_i  in  128  tag from ascon
end_tag_i  in  1  tag_i is valid this cycle
byte_o  out  8  output byte
byte_valid_o  out  1  byte_o is valid
byte_ready_i  in  1  sink accepts byte_o
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse after the last byte is accepted
overflow_o  out  1  sticky; a block arrived while the buffer was full

Behaviour:
- Reset (reset_i=0, asynchronous): state=IDLE. All outputs are 0, buffer=0, tag register=0, block_cnt=0, byte_cnt=0.
- States: IDLE, CAPTURE, WAIT_TAG, SEND_CIPHER, SEND_TAG, DONE.
- IDLE:
  - start_i=1 -> CAPTURE; clears block_cnt, byte_cnt and overflow_o.
  - cipher_valid_i and end_tag_i are ignored.
- CAPTURE:
  - On cipher_valid_i with block_cnt<NB_BLOCKS: store cipher_i at buffer[1471-64*block_cnt -: 64], i.e. the first block is most significant. Then block_cnt++.
  - On cipher_valid_i with block_cnt=NB_BLOCKS: drop the block and set overflow_o=1.
  - end_cipher_i=1 or block_cnt reaching NB_BLOCKS -> WAIT_TAG.
  - end_tag_i=1 in CAPTURE: capture tag_i, then go straight to SEND_CIPHER. A cipher_valid_i in the same cycle is also captured.
- WAIT_TAG:
  - end_tag_i=1 -> capture tag_i, then SEND_CIPHER.
  - Late cipher_valid_i: dropped, and overflow_o=1 if the buffer is full.
- SEND_CIPHER:
  - byte_valid_o=1 starting the cycle after tag capture (1-cycle latency).
  - byte_o = buffer byte byte_cnt, MSB first.
  - A transfer occurs when byte_valid_o & byte_ready_i; byte_cnt++ on each transfer.
  - byte_o must stay stable while byte_valid_o=1 and byte_ready_i=0.
  - Only received bytes are sent (block_cnt*8 bytes). After the last one -> SEND_TAG.
  - If block_cnt=0, go directly to SEND_TAG.
- SEND_TAG: sends 16 tag bytes, tag_i[127:120] first, with the same handshake. After the 16th transfer -> DONE.
- DONE: done_o=1 for one cycle, then IDLE. byte_valid_o=0.
- start_i outside IDLE is ignored.
- Back-to-back operation: with byte_ready_i held at 1, one byte is transferred per cycle, with no bubbles between the cipher and tag phases.
- block_cnt is 5 bits. byte_cnt is 8 bits and is reset at the start of SEND_TAG.
- Reset asserted mid-frame aborts immediately. byte_valid_o drops asynchronously and no done_o pulse is produced.

Optional Feature:
ASCON_COLLECT_HEADER_EN:
- When defined, SEND_CIPHER is preceded by two header bytes: 0xA5, then the payload length in bytes (block_cnt*8+16; 0xC8 for a full frame). Both header bytes use the same handshake.
- When not defined, the first byte transferred is cipher byte 0. No extra logic is present.

Test Plan:
- Full frame: reset, start_i pulse, 23 blocks with cipher_i=64'h0101..01 * (i+1), end_cipher_i, then end_tag_i with tag=128'h00112233_44556677_8899AABB_CCDDEEFF, byte_ready_i=1 -> 184 cipher bytes (0x01 x8, 0x02 x8, ... 0x17 x8), then 00,11,...,FF; done_o pulses once; overflow_o=0.
- Backpressure: byte_ready_i toggled 1/0 every cycle during SEND -> byte_o never changes while byte_ready_i=0; exactly 200 transfers; byte sequence identical to the full-frame case.
- Short frame: 3 blocks, then end_cipher_i and end_tag_i -> 24 cipher bytes, then 16 tag bytes (40 total); done_o pulses.
- Overflow: 24 cipher_valid_i pulses before end_tag_i -> overflow_o=1; the 24th block is absent from the output; 200 bytes are sent.
- Reset mid-SEND after 50 bytes: reset_i=0 for 2 cycles -> byte_valid_o=0, busy_o=0, no done_o. A following start_i restarts a clean frame.
- With ASCON_COLLECT_HEADER_EN: full frame -> the first bytes are A5, C8, then the 200-byte payload; 3-block frame -> A5, 28.
